// File: rtl/spi_mul_sequencer.sv
// Control FSM for the SPI multiplier: receives A and B, starts the multiplier, shifts the product out.
// Optional MUL_TIMEOUT_EN bounds the WAIT_MUL dwell to TIMEOUT_CYCLES clocks.
module spi_mul_sequencer #(
   parameter int unsigned WIDTH          = 8,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 cs_n,
   input  logic                 sclk_posedge,
   input  logic                 sclk_negedge,
   input  logic [WIDTH-1:0]     sr_parallel_out,
   input  logic                 mul_done,
   input  logic [2*WIDTH-1:0]   mul_product,
   output logic [1:0]           sr_mode,
   output logic                 sr_strobe,
   output logic [WIDTH-1:0]     sr_parallel_in,
   output logic [WIDTH-1:0]     op_a,
   output logic [WIDTH-1:0]     op_b,
   output logic                 mul_start,
   output logic                 miso,
   output logic                 miso_en,
   output logic                 busy,
   output logic                 frame_err
);

   localparam int unsigned     CntW    = $clog2(WIDTH + 1);
   localparam logic [CntW-1:0] CntFull = CntW'(WIDTH);
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   localparam logic [1:0] ModeHold  = 2'b00;
   localparam logic [1:0] ModeLeft  = 2'b10;
   localparam logic [1:0] ModePload = 2'b11;

   typedef enum logic [3:0] {
      StIdle, StRxA, StRxB, StWaitMul, StLoadHi, StTxHi, StLoadLo, StTxLo, StDone, StDrain
   } state_e;

   state_e            state_q;
   logic [CntW-1:0]   cnt_q;
   logic              cs_n_q;
   logic [WIDTH-1:0]  sr_pin_q;
   logic [WIDTH-1:0]  op_a_q;
   logic [WIDTH-1:0]  op_b_q;
   logic              mul_start_q;
   logic              miso_en_q;
   logic              frame_err_q;

`ifdef MUL_TIMEOUT_EN
   localparam int unsigned     TmoW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
   logic [TmoW-1:0] tmo_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tmo_q <= '0;
      end else if (state_q != StWaitMul) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_q + 1'b1;
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         cs_n_q      <= 1'b1;
         sr_pin_q    <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         mul_start_q <= 1'b0;
         miso_en_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         cs_n_q      <= cs_n;
         mul_start_q <= 1'b0;
         if (state_q != StIdle && cs_n) begin
            // Master released chip select: abort, flagging it unless the frame had finished.
            state_q   <= StIdle;
            cnt_q     <= '0;
            miso_en_q <= 1'b0;
            if (state_q != StDone && state_q != StDrain) frame_err_q <= 1'b1;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (cs_n_q && !cs_n) begin
                     state_q     <= StRxA;
                     cnt_q       <= '0;
                     frame_err_q <= 1'b0;
                  end
               end
               StRxA, StRxB: begin
                  if (cnt_q == CntFull) begin
                     cnt_q <= '0;
                     if (state_q == StRxA) begin
                        op_a_q  <= sr_parallel_out;
                        state_q <= StRxB;
                     end else begin
                        op_b_q      <= sr_parallel_out;
                        mul_start_q <= 1'b1;
                        state_q     <= StWaitMul;
                     end
                  end else if (sclk_posedge) begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               StWaitMul: begin
                  if (sclk_posedge) begin
                     frame_err_q <= 1'b1;
                     state_q     <= StDrain;
                  end else if (mul_done && !mul_start_q) begin
                     // mul_done is ignored during the start pulse, when it may still be stale.
                     sr_pin_q  <= mul_product[2*WIDTH-1:WIDTH];
                     miso_en_q <= 1'b1;
                     state_q   <= StLoadHi;
                  end
`ifdef MUL_TIMEOUT_EN
                  else if (tmo_q == TmoLast) begin
                     frame_err_q <= 1'b1;
                     state_q     <= StDrain;
                  end
`endif
               end
               StLoadHi: state_q <= StTxHi;
               StTxHi, StTxLo: begin
                  if (sclk_negedge) begin
                     if (cnt_q == CntLast) begin
                        cnt_q <= '0;
                        if (state_q == StTxHi) begin
                           sr_pin_q <= mul_product[WIDTH-1:0];
                           state_q  <= StLoadLo;
                        end else begin
                           miso_en_q <= 1'b0;
                           state_q   <= StDone;
                        end
                     end else begin
                        cnt_q <= cnt_q + 1'b1;
                     end
                  end
               end
               StLoadLo: state_q <= StTxLo;
               StDone, StDrain: ;
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   // Shift strobes follow the SCLK pulse in the same clk so the register captures on that edge.
   always_comb begin
      sr_mode   = ModeHold;
      sr_strobe = 1'b0;
      case (state_q)
         StRxA, StRxB: begin
            if (sclk_posedge && cnt_q != CntFull) begin
               sr_mode   = ModeLeft;
               sr_strobe = 1'b1;
            end
         end
         StTxHi, StTxLo: begin
            if (sclk_negedge) begin
               sr_mode   = ModeLeft;
               sr_strobe = 1'b1;
            end
         end
         StLoadHi, StLoadLo: begin
            sr_mode   = ModePload;
            sr_strobe = 1'b1;
         end
         default: ;
      endcase
   end

   assign sr_parallel_in = sr_pin_q;
   assign op_a           = op_a_q;
   assign op_b           = op_b_q;
   assign mul_start      = mul_start_q;
   assign miso_en        = miso_en_q;
   assign miso           = miso_en_q & sr_parallel_out[WIDTH-1];
   assign busy           = (state_q != StIdle);
   assign frame_err      = frame_err_q;

endmodule
